// File: rtl/fetch_bpu.sv
// rtl/fetch_bpu.sv - fetch stage with integrated bimodal branch predictor
//
// Holds the program counter, decodes j/jal/beq/bne from the instruction
// returned by instruction memory in the same cycle, predicts conditional
// branches from a table of 2-bit saturating counters and redirects on a
// misprediction reported by EX.
//
// Parameters:
//   PC_W       PC / instruction-address width in words
//   BHT_DEPTH  predictor entries (power of two, >= 2), indexed by low PC bits
//   RESET_PC   PC value after reset
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   hold                stall, PC keeps its value (a mispredict still redirects)
//   instr               instruction at the current PC
//   jr, jr_addr         jump-register redirect and target
//   ex_branch           EX holds a resolved conditional branch
//   ex_taken, ex_pred   actual outcome and the prediction it carried
//   ex_pc               PC of the resolving branch (selects the counter)
//   ex_pc_plus1         fall-through address of the branch
//   ex_target           taken target of the branch
//   pc, pc_plus1        current PC (imem address) and pc+1 modulo 2^PC_W
//   pred_taken          prediction for instr, 0 unless instr is beq/bne
//   flush               misprediction this cycle, younger IF/ID contents invalid
//   stat_branches       resolved-branch count
//   stat_mispredicts    misprediction count
//
// Build option: FETCH_BPU_STATS_EN builds the two 32-bit statistics
// counters; without it both stat outputs are tied to 0.

module fetch_bpu #(
   parameter int              PC_W      = 10,
   parameter int              BHT_DEPTH = 16,
   parameter logic [PC_W-1:0] RESET_PC  = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            hold,
   input  logic [31:0]     instr,
   input  logic            jr,
   input  logic [PC_W-1:0] jr_addr,
   input  logic            ex_branch,
   input  logic            ex_taken,
   input  logic            ex_pred,
   input  logic [PC_W-1:0] ex_pc,
   input  logic [PC_W-1:0] ex_pc_plus1,
   input  logic [PC_W-1:0] ex_target,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] pc_plus1,
   output logic            pred_taken,
   output logic            flush,
   output logic [31:0]     stat_branches,
   output logic [31:0]     stat_mispredicts
);

   localparam int              IDX_W = $clog2(BHT_DEPTH);
   localparam logic [5:0]      OP_J   = 6'h02;
   localparam logic [5:0]      OP_JAL = 6'h03;
   localparam logic [5:0]      OP_BEQ = 6'h04;
   localparam logic [5:0]      OP_BNE = 6'h05;
   localparam logic [PC_W-1:0] PC_ONE = 1;

   logic [1:0]      bht [BHT_DEPTH];
   logic [5:0]      opcode;
   logic [PC_W-1:0] addr;
   logic            is_jump;
   logic            is_branch;
   logic [1:0]      ctr_rd;
   logic [1:0]      ctr_wr;
   logic            mispredict;
   logic [PC_W-1:0] pc_next;

   // Address bits above the PC width and the high ex_pc bits are not needed.
   logic unused_bits;
   assign unused_bits = &{1'b0, instr[25:PC_W], ex_pc[PC_W-1:IDX_W]};

   assign opcode    = instr[31:26];
   assign addr      = instr[PC_W-1:0];
   assign is_jump   = (opcode == OP_J) || (opcode == OP_JAL);
   assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);

   // Read and write ports of the table; a same-index read in the update
   // cycle sees the old value because the write only lands at the edge.
   assign ctr_rd = bht[pc[IDX_W-1:0]];
   assign ctr_wr = bht[ex_pc[IDX_W-1:0]];

   assign pc_plus1   = pc + PC_ONE;
   assign pred_taken = is_branch & ctr_rd[1];
   assign mispredict = ex_branch & (ex_taken != ex_pred);
   assign flush      = mispredict;

   // Redirect priority: a mispredict outranks hold and jr, because the jr
   // and anything else in IF is younger than the branch and is being flushed.
   always_comb begin
      pc_next = pc_plus1;
      if (mispredict) begin
         pc_next = ex_taken ? ex_target : ex_pc_plus1;
      end else if (hold) begin
         pc_next = pc;
      end else if (jr) begin
         pc_next = jr_addr;
      end else if (is_jump) begin
         pc_next = addr;
      end else if (pred_taken) begin
         pc_next = pc_plus1 + addr;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc <= RESET_PC;
      end else begin
         pc <= pc_next;
      end
   end

   // Counter training follows every resolution, regardless of hold.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < BHT_DEPTH; i++) begin
            bht[i] <= 2'b01;
         end
      end else if (ex_branch) begin
         if (ex_taken) begin
            if (ctr_wr != 2'b11) begin
               bht[ex_pc[IDX_W-1:0]] <= ctr_wr + 2'd1;
            end
         end else begin
            if (ctr_wr != 2'b00) begin
               bht[ex_pc[IDX_W-1:0]] <= ctr_wr - 2'd1;
            end
         end
      end
   end

`ifdef FETCH_BPU_STATS_EN
   logic [31:0] br_cnt;
   logic [31:0] mp_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         br_cnt <= '0;
         mp_cnt <= '0;
      end else begin
         if (ex_branch) begin
            br_cnt <= br_cnt + 32'd1;
         end
         if (mispredict) begin
            mp_cnt <= mp_cnt + 32'd1;
         end
      end
   end

   assign stat_branches    = br_cnt;
   assign stat_mispredicts = mp_cnt;
`else
   assign stat_branches    = 32'd0;
   assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_bpu.sv
// tb/tb_fetch_bpu.sv - scoreboard testbench for fetch_bpu
module tb_fetch_bpu;

`ifdef FETCH_BPU_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        hold;
   logic [31:0] instr;
   logic        jr;
   logic [9:0]  jr_addr;
   logic        ex_branch;
   logic        ex_taken;
   logic        ex_pred;
   logic [9:0]  ex_pc;
   logic [9:0]  ex_pc_plus1;
   logic [9:0]  ex_target;
   logic [9:0]  pc;
   logic [9:0]  pc_plus1;
   logic        pred_taken;
   logic        flush;
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;

   fetch_bpu #(
      .PC_W      (10),
      .BHT_DEPTH (16),
      .RESET_PC  (10'd0)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .hold             (hold),
      .instr            (instr),
      .jr               (jr),
      .jr_addr          (jr_addr),
      .ex_branch        (ex_branch),
      .ex_taken         (ex_taken),
      .ex_pred          (ex_pred),
      .ex_pc            (ex_pc),
      .ex_pc_plus1      (ex_pc_plus1),
      .ex_target        (ex_target),
      .pc               (pc),
      .pc_plus1         (pc_plus1),
      .pred_taken       (pred_taken),
      .flush            (flush),
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [9:0]  pc;
      logic        pred;
      logic        flush;
      logic        cs;
      logic [31:0] sb;
      logic [31:0] sm;
   } exp_t;

   exp_t  q[$];
   string qn[$];
   int    checks = 0;
   int    errors = 0;

   function automatic logic [31:0] mk(input logic [5:0] op, input logic [9:0] a);
      return {op, 16'd0, a};
   endfunction

   task automatic exp_o(input string nm, input logic [9:0] p, input logic pr, input logic fl);
      exp_t e;
      e.pc = p; e.pred = pr; e.flush = fl; e.cs = 1'b0; e.sb = '0; e.sm = '0;
      q.push_back(e);
      qn.push_back(nm);
   endtask

   task automatic exp_s(input string nm, input logic [9:0] p, input logic [31:0] sb, input logic [31:0] sm);
      exp_t e;
      e.pc = p; e.pred = 1'b0; e.flush = 1'b0; e.cs = 1'b1; e.sb = sb; e.sm = sm;
      q.push_back(e);
      qn.push_back(nm);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   // Monitor: outputs are stable at the falling edge; pop and compare.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t  e;
         string nm;
         logic [9:0] pp1;
         e  = q.pop_front();
         nm = qn.pop_front();
         pp1 = e.pc + 10'd1;
         chk({nm, ".pc"}, {22'd0, pc}, {22'd0, e.pc});
         chk({nm, ".pc_plus1"}, {22'd0, pc_plus1}, {22'd0, pp1});
         chk({nm, ".pred_taken"}, {31'd0, pred_taken}, {31'd0, e.pred});
         chk({nm, ".flush"}, {31'd0, flush}, {31'd0, e.flush});
         if (e.cs) begin
            chk({nm, ".stat_branches"}, stat_branches, e.sb);
            chk({nm, ".stat_mispredicts"}, stat_mispredicts, e.sm);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      hold = 0; instr = '0; jr = 0; jr_addr = '0;
      ex_branch = 0; ex_taken = 0; ex_pred = 0;
      ex_pc = '0; ex_pc_plus1 = '0; ex_target = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time %0t limit 100000", $time);
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      clr();
      #2 rst = 1'b0;
      tick();
      exp_o("rst_hold", 10'h000, 0, 0); tick();
      rst = 1'b1;
      exp_o("rel_pc0", 10'h000, 0, 0); tick();
      exp_o("rel_pc1", 10'h001, 0, 0); tick();
      exp_o("rel_pc2", 10'h002, 0, 0); tick();
      exp_o("adv_pc3", 10'h003, 0, 0); tick();
      exp_o("adv_pc4", 10'h004, 0, 0); tick();

      // jump and jr-over-jump
      instr = mk(6'h02, 10'h040);
      exp_o("j_pc5", 10'h005, 0, 0); tick();
      instr = '0;
      exp_o("j_tgt", 10'h040, 0, 0); tick();
      instr = mk(6'h02, 10'h040); jr = 1; jr_addr = 10'h012;
      exp_o("jr_vs_j", 10'h041, 0, 0); tick();
      clr();
      exp_o("jr_tgt", 10'h012, 0, 0); tick();

      // saturate counter 3 while held
      hold = 1; ex_branch = 1; ex_taken = 1; ex_pred = 1; ex_pc = 10'd3;
      for (int i = 0; i < 4; i++) begin
         exp_o("sat_train", 10'h013, 0, 0); tick();
      end
      clr(); jr = 1; jr_addr = 10'd3;
      exp_o("hold_pc", 10'h013, 0, 0); tick();
      clr(); instr = mk(6'h04, 10'd5);
      exp_o("sat_pred", 10'd3, 1, 0); tick();
      clr();
      exp_o("sat_tgt", 10'd9, 0, 0); tick();
      ex_branch = 1; ex_taken = 0; ex_pred = 0; ex_pc = 10'd3;
      exp_o("sat_nt", 10'd10, 0, 0); tick();
      clr(); jr = 1; jr_addr = 10'd3;
      exp_o("pc11", 10'd11, 0, 0); tick();
      clr(); instr = mk(6'h05, 10'd5);
      exp_o("sat_nt_pred", 10'd3, 1, 0); tick();

      // predicted branch wrapping past the top of the address space
      clr(); ex_branch = 1; ex_taken = 1; ex_pred = 1; ex_pc = 10'd14;
      jr = 1; jr_addr = 10'h3FE;
      exp_o("pc9", 10'd9, 0, 0); tick();
      clr(); instr = mk(6'h04, 10'd3);
      exp_o("wrap_pred", 10'h3FE, 1, 0); tick();
      clr(); jr = 1; jr_addr = 10'h3FF;
      exp_o("wrap_tgt", 10'd2, 0, 0); tick();
      clr();
      exp_o("pc_max", 10'h3FF, 0, 0); tick();

      // mispredict under hold, also beating jr
      hold = 1; ex_branch = 1; ex_pred = 1; ex_taken = 0; ex_pc = 10'd14;
      ex_pc_plus1 = 10'h021; ex_target = 10'h077; jr = 1; jr_addr = 10'h012;
      exp_o("mp_hold", 10'h000, 0, 1); tick();
      clr();
      exp_o("mp_tgt", 10'h021, 0, 0); tick();
      jr = 1; jr_addr = 10'd14;
      exp_o("pc22", 10'h022, 0, 0); tick();
      clr(); instr = mk(6'h04, 10'd3);
      exp_o("mp_ctr", 10'd14, 0, 0); tick();
      clr(); ex_branch = 1; ex_taken = 1; ex_pred = 0; ex_pc = 10'd7; ex_target = 10'h100;
      exp_o("mp_taken", 10'd15, 0, 1); tick();

      // same-index read and write in one cycle
      clr(); jr = 1; jr_addr = 10'd7;
      exp_o("pc100", 10'h100, 0, 0); tick();
      clr(); instr = mk(6'h04, 10'd2); ex_branch = 1; ex_taken = 0; ex_pred = 0; ex_pc = 10'd7;
      exp_o("rw_pred", 10'd7, 1, 0); tick();
      clr(); jr = 1; jr_addr = 10'd7;
      exp_o("rw_tgt", 10'd10, 0, 0); tick();
      clr(); instr = mk(6'h04, 10'd2);
      exp_o("rw_ctr", 10'd7, 0, 0); tick();

      // reset mid-run clears pc, counters and statistics
      clr(); rst = 1'b0; instr = mk(6'h04, 10'd1);
      exp_s("mrst", 10'h000, 32'd0, 32'd0); tick();
      exp_o("mrst2", 10'h000, 0, 0); tick();
      rst = 1'b1; clr();
      exp_o("mrst_rel0", 10'd0, 0, 0); tick();
      exp_o("mrst_rel1", 10'd1, 0, 0); tick();
      exp_o("mrst_rel2", 10'd2, 0, 0); tick();
      instr = mk(6'h04, 10'd1);
      exp_o("rst_ctr3", 10'd3, 0, 0); tick();

      // 10 resolutions, first 3 mispredicted, all under hold
      clr(); hold = 1; ex_pc = 10'd9; ex_pc_plus1 = 10'd4;
      for (int i = 0; i < 10; i++) begin
         ex_branch = 1; ex_taken = 0; ex_pred = (i < 3);
         exp_o("stat_br", 10'd4, 0, (i < 3)); tick();
      end
      clr();
      exp_s("stats", 10'd4, STATS ? 32'd10 : 32'd0, STATS ? 32'd3 : 32'd0); tick();

      @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_bpu.md
# fetch_bpu

Parametrised fetch stage with an integrated bimodal branch predictor, successor to the fixed-width 10-bit fetch unit. Holds the program counter, decodes jump and branch opcodes from the instruction currently presented by instruction memory, predicts conditional branches with a table of 2-bit saturating counters, and redirects on misprediction reported by EX. It sits between instruction memory and the IF/ID pipeline register.

## Interface
- PC_W, 10, PC and instruction-address width in words
- BHT_DEPTH, 16, predictor entries, power of two, ≥2; index = PC[log2(BHT_DEPTH)-1:0]
- RESET_PC, 0, PC value after reset
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- hold  in  1  stall; PC keeps its value
- instr  in  32  instruction at current PC (memory returns it within the same cycle)
- jr  in  1  jump-register redirect valid
- jr_addr  in  PC_W  jump-register target
- ex_branch  in  1  EX holds a resolved conditional branch
- ex_taken  in  1  actual outcome
- ex_pred  in  1  prediction carried down the pipe with that branch
- ex_pc  in  PC_W  PC of the resolving branch
- ex_pc_plus1  in  PC_W  fall-through address of the branch
- ex_target  in  PC_W  taken target of the branch
- pc  out  PC_W  current PC, also instruction-memory address
- pc_plus1  out  PC_W  pc+1, modulo 2^PC_W
- pred_taken  out  1  prediction for instr; 0 when instr is not beq/bne
- flush  out  1  misprediction this cycle; younger IF/ID contents are invalid
- stat_branches  out  32  resolved-branch count
- stat_mispredicts  out  32  misprediction count

## Operation
- Opcode = instr[31:26]; j = 0x02, jal = 0x03, beq = 0x04, bne = 0x05. Field addr = instr[PC_W-1:0].
- mispredict = ex_branch & (ex_taken != ex_pred); flush = mispredict.
- next PC priority, highest first:
  1. mispredict: ex_target if ex_taken, else ex_pc_plus1; overrides hold.
  2. hold: pc unchanged.
  3. jr: jr_addr.
  4. j/jal: addr.
  5. beq/bne with counter[idx(pc)][1] = 1: pc_plus1 + addr, modulo 2^PC_W.
  6. otherwise pc_plus1.
- pred_taken = (opcode is beq/bne) & counter[idx(pc)][1]; combinational.
- Counters: 00 strongly not-taken, 01 weak NT, 10 weak T, 11 strong T. Reset value 01.
- On ex_branch, counter[idx(ex_pc)] increments if ex_taken, else decrements, saturating at 11/00. Update is independent of hold and of mispredict.
- Arithmetic is unsigned PC_W-bit and wraps: pc = 2^PC_W−1 gives pc_plus1 = 0.

## Timing
- Asynchronous reset: pc = RESET_PC, all counters = 01, stats = 0, immediately on rst low. While rst is low, no update occurs. First fetch is at RESET_PC on the first edge after release.
- The PC register is the only latency: next PC is computed combinationally from the current cycle's inputs and loaded on the next rising edge.
- Prediction read and counter write to the same index in one cycle: the read sees the old value, and the write lands at the edge.
- A mispredict and a jr in the same cycle: the mispredict wins, because the jr instruction is younger and is being flushed.
- flush is high only in the mispredict cycle and is not registered.

## Configuration
- FETCH_BPU_STATS_EN defined:
  - stat_branches increments on every ex_branch cycle.
  - stat_mispredicts increments on every mispredict cycle.
  - Both are 32-bit, wrap at 2^32, and count even under hold.
- Not defined: no counters are built, and both stat outputs are tied to 0.

## Test plan
- Reset: hold rst low mid-run → pc = 0, pred_taken = 0, flush = 0. Release with instr = NOP → pc advances 0, 1, 2.
- Jump: pc = 5, instr = j with addr = 0x40 → next pc = 0x40. Same with jr = 1, jr_addr = 0x12 → pc = 0x12, since jr beats the j opcode.
- Predicted branch: pc = 0x3FE, counter = 10, instr = beq with addr = 3 → pred_taken = 1, next pc = (0x3FF+3) mod 1024 = 2.
- Mispredict under hold: hold = 1, ex_branch = 1, ex_pred = 1, ex_taken = 0, ex_pc_plus1 = 0x21 → flush = 1, next pc = 0x21. Counter for idx(ex_pc) goes 10→01.
- Saturation: four taken resolutions at ex_pc = 3 → counter 01→10→11→11. A beq at pc = 3 then predicts taken. One not-taken resolution → 10, still taken.
- With FETCH_BPU_STATS_EN: 10 branches including 3 mispredicts → stat_branches = 10, stat_mispredicts = 3. Without the macro, both read 0.
